// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Queue entries are sized for the widest supported PC/instruction.
package fetch_pkg;
  localparam int ENTRY_PC_W   = 32;
  localparam int ENTRY_INST_W = 32;
  localparam int PC_INC       = 4;
  localparam logic [ENTRY_PC_W-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]   pc;
    logic [ENTRY_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; flush takes priority over push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output fetch_entry_t  head_entry,
  output logic          valid,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // DEPTH is a power of two, so pointers wrap without compare logic
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = mem[rd_ptr];
  assign valid      = (count != '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding ROM read, redirect squash,
// and a credit-controlled queue feeding decode.
module fetch_unit #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(fetch_pkg::DEFAULT_RESET_PC)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable_in,
  input  logic                       redirect_in,
  input  logic [PC_W-1:0]            redirect_pc_in,
  output logic                       rom_re_out,
  output logic [PC_W-1:0]            rom_addr_out,
  input  logic [INST_W-1:0]          rom_data_in,
  output logic                       inst_valid_out,
  input  logic                       inst_ready_in,
  output logic [INST_W-1:0]          inst_out,
  output logic [PC_W-1:0]            inst_pc_out,
  output logic [PC_W-1:0]            inst_pc_plus4_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);
  import fetch_pkg::*;

  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW1 = CW + 1;

  logic [PC_W-1:0] pc, tag;
  logic            inflight, pop, push, credit_ok, issue;
  fetch_entry_t    push_entry, head_entry;

  assign pop  = inst_valid_out & inst_ready_in;
  assign push = inflight & ~redirect_in;

  // Slot reserved for the in-flight return; a same-cycle pop frees one now
  assign credit_ok = ({1'b0, count_out} + CW1'(inflight)) < (CW1'(DEPTH) + CW1'(pop));
  assign issue     = enable_in & ~redirect_in & ~reset & credit_ok;

  assign rom_re_out   = issue;
  assign rom_addr_out = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      tag      <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_in) begin
      pc       <= {redirect_pc_in[PC_W-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc  <= pc + PC_W'(PC_INC);
        tag <= pc;
      end
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = ENTRY_PC_W'(tag);
    push_entry.inst = ENTRY_INST_W'(rom_data_in);
  end

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_in),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .valid      (inst_valid_out),
    .count      (count_out)
  );

  assign inst_out          = INST_W'(head_entry.inst);
  assign inst_pc_out       = PC_W'(head_entry.pc);
  assign inst_pc_plus4_out = inst_pc_out + PC_W'(PC_INC);
endmodule
